// File: rtl/mole_pkg.sv
// Shared types and constants for the whack-a-mole round controller.
package mole_pkg;

  localparam int NUM_MOLES = 18;

  // Fibonacci taps for x^32 + x^22 + x^2 + x + 1 (bits 31, 21, 1, 0).
  localparam int                LFSR_W    = 32;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 32'h8020_0003;

  typedef logic [NUM_MOLES-1:0] mole_vec_t;
  typedef logic [7:0]           round_cnt_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SPAWN,
    ST_SHOW,
    ST_REPORT,
    ST_GAP,
    ST_DONE
  } mole_state_t;

endpackage

// File: rtl/mole_spawner_if.sv
// Board-side inputs and scorer-side outputs of the mole spawner; master is the spawner.
interface mole_spawner_if;
  import mole_pkg::*;

  logic       start;
  mole_vec_t  hit_in;
  mole_vec_t  led_moles;
  mole_vec_t  hit_reg;
  logic       round_done;
  round_cnt_t round_count;
  logic       game_over;

  modport master (
    input  start, hit_in,
    output led_moles, hit_reg, round_done, round_count, game_over
  );

  modport slave (
    output start, hit_in,
    input  led_moles, hit_reg, round_done, round_count, game_over
  );

endinterface

// File: rtl/mole_lfsr.sv
// Seedable 32-bit Fibonacci LFSR; free-runs every cycle, loads SEED on reset.
module mole_lfsr
  import mole_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 32'hACE1_2024
) (
  input  logic              clk,
  input  logic              reset,
  output logic [LFSR_W-1:0] lfsr
);

  logic feedback;

  assign feedback = ^(lfsr & LFSR_TAPS);

  always_ff @(posedge clk) begin
    if (!reset) begin
      lfsr <= SEED;
    end else begin
      lfsr <= {lfsr[LFSR_W-2:0], feedback};
    end
  end

endmodule

// File: rtl/mole_spawner.sv
// Whack-a-mole round controller: spawns a random lit pattern, collects hits, reports once per round.
// Define MOLE_EARLY_CLEAR_EN to end a round's window as soon as every lit mole has been hit.
module mole_spawner
  import mole_pkg::*;
#(
  parameter int                WINDOW_CYCLES = 50_000_000,
  parameter int                GAP_CYCLES    = 12_500_000,
  parameter int                NUM_ROUNDS    = 20,
  parameter logic [LFSR_W-1:0] SEED          = 32'hACE1_2024
) (
  input  logic           clk,
  input  logic           reset,
  mole_spawner_if.master bus
);

  // Window and gap timing share one down-counter.
  localparam int MAX_CYCLES = (WINDOW_CYCLES > GAP_CYCLES) ? WINDOW_CYCLES : GAP_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t WIN_LOAD = cnt_t'(WINDOW_CYCLES - 1);
  localparam cnt_t GAP_LOAD = cnt_t'(GAP_CYCLES - 1);

  logic [LFSR_W-1:0] lfsr;
  mole_state_t       state;
  cnt_t              cnt;
  mole_vec_t         pattern;
  mole_vec_t         acc;
  mole_vec_t         hit_prev;
  mole_vec_t         acc_next;
  mole_vec_t         spawn_raw;
  mole_vec_t         spawn_pat;
  logic              window_end;

  mole_vec_t         led_q;
  mole_vec_t         hit_q;
  logic              done_q;
  round_cnt_t        rc_q;
  logic              over_q;

  mole_lfsr #(.SEED(SEED)) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .lfsr  (lfsr)
  );

  // Only fresh presses on lit moles count; an empty random draw falls back to a single mole.
  always_comb begin
    acc_next   = acc | (bus.hit_in & ~hit_prev & pattern);
    spawn_raw  = lfsr[NUM_MOLES-1:0] & lfsr[LFSR_W-1 -: NUM_MOLES];
    spawn_pat  = (spawn_raw != '0) ? spawn_raw : (mole_vec_t'(1) << lfsr[3:0]);
    window_end = (cnt == '0);
`ifdef MOLE_EARLY_CLEAR_EN
    window_end = window_end || (acc_next == pattern);
`else
    window_end = window_end;
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      pattern  <= '0;
      acc      <= '0;
      hit_prev <= '0;
      led_q    <= '0;
      hit_q    <= '0;
      done_q   <= 1'b0;
      rc_q     <= '0;
      over_q   <= 1'b0;
    end else begin
      hit_prev <= bus.hit_in;
      unique case (state)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            state  <= ST_SPAWN;
            rc_q   <= '0;
            over_q <= 1'b0;
          end
        end
        ST_SPAWN: begin
          pattern <= spawn_pat;
          led_q   <= spawn_pat;
          acc     <= '0;
          cnt     <= WIN_LOAD;
          state   <= ST_SHOW;
        end
        ST_SHOW: begin
          acc <= acc_next;
          if (window_end) begin
            state  <= ST_REPORT;
            hit_q  <= acc_next;
            done_q <= 1'b1;
            rc_q   <= rc_q + 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_REPORT: begin
          hit_q  <= '0;
          done_q <= 1'b0;
          led_q  <= '0;
          cnt    <= GAP_LOAD;
          state  <= ST_GAP;
        end
        ST_GAP: begin
          if (cnt == '0) begin
            if (rc_q == round_cnt_t'(NUM_ROUNDS)) begin
              state  <= ST_DONE;
              over_q <= 1'b1;
            end else begin
              state <= ST_SPAWN;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.led_moles   = led_q;
  assign bus.hit_reg     = hit_q;
  assign bus.round_done  = done_q;
  assign bus.round_count = rc_q;
  assign bus.game_over   = over_q;

endmodule

// File: doc/mole_spawner.md
# mole_spawner

Round controller and mole-pattern generator for the whack-a-mole game: the producer side of the `led_moles`/`hit_reg` interface that the score counter consumes. It picks a pseudo-random set of lit moles each round and holds them for a fixed window. It collects player hits on lit moles, then presents the round result to the scorer for exactly one cycle. Sits between the board switch/button inputs and the scoring logic.

## Interface
- `NUM_MOLES`, 18: mole/LED count; fixed at 18 by the scorer interface.
- `WINDOW_CYCLES`, 50_000_000: cycles each pattern is shown (≥2).
- `GAP_CYCLES`, 12_500_000: dark cycles between rounds (≥1).
- `NUM_ROUNDS`, 20: rounds per game (1..255).
- `SEED`, 32'hACE1_2024: LFSR reset value; must be nonzero.
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-low.
- `start` in 1: level; sampled in IDLE/DONE to begin a game.
- `hit_in` in 18: raw, already-synchronised hit buttons, active-high.
- `led_moles` out 18: current lit pattern.
- `hit_reg` out 18: round hits, nonzero only in the report cycle.
- `round_done` out 1: one-cycle strobe marking the report cycle.
- `round_count` out 8: rounds completed in the current game.
- `game_over` out 1: high in DONE.

## Operation
- States: IDLE, SPAWN, SHOW, REPORT, GAP, DONE.
- Reset (`reset`=0 at a clk edge), from any state mid-operation:
  - State goes to IDLE; LFSR loads SEED.
  - All outputs, the hit accumulator, the edge-detect register and the counters clear to 0.
- LFSR:
  - 32-bit Fibonacci, polynomial x^32+x^22+x^2+x+1.
  - Advances every cycle in every state except under reset.
- IDLE/DONE, `start`=1 → SPAWN. Entry from IDLE or DONE clears `round_count` and `game_over`.
- SPAWN (1 cycle):
  - Loads `pattern` = lfsr[17:0] & lfsr[31:14].
  - If that is zero, it loads 18'b1 << lfsr[3:0] instead, so `pattern` is never empty.
  - Clears the accumulator; → SHOW.
- SHOW (WINDOW_CYCLES cycles):
  - `led_moles`=pattern.
  - Each cycle, accumulator |= (hit_in & ~hit_in_prev & pattern). Only rising edges on lit moles count; holding a button counts once; hits on dark moles are discarded.
  - At window end → REPORT.
- REPORT (1 cycle):
  - `led_moles`=pattern, `hit_reg`=accumulator, `round_done`=1.
  - `round_count` increments.
  - → GAP.
- GAP (GAP_CYCLES cycles): `led_moles`=0. At exit → DONE if `round_count`==NUM_ROUNDS, else SPAWN.
- Hits arriving in SPAWN, REPORT, GAP, IDLE or DONE are ignored. `hit_in_prev` still tracks in every state, so a button held across SPAWN does not register in SHOW.
- `hit_reg` is 0 in every cycle except REPORT. The scorer integrates every clock, so each round contributes exactly once.

## Timing
- `start` sampled high at edge N → SPAWN during N..N+1, SHOW from edge N+1. `led_moles` is registered and valid from N+1.
- Rising edge on `hit_in` in SHOW cycle k enters the accumulator at edge k+1. An edge in the final SHOW cycle is counted.
- SHOW→REPORT→GAP are back to back; report latency is 1 cycle after window close.
- Round period = 1 + WINDOW_CYCLES + 1 + GAP_CYCLES cycles.
- `round_count` is valid with `round_done` at the REPORT-exit edge.
- `start` held high through DONE restarts the game on the next cycle.
- All outputs are registered; no combinational input→output path.

## Configuration
- `MOLE_EARLY_CLEAR_EN` defined:
  - In SHOW, when the next accumulator value == pattern, the state leaves SHOW at that edge for REPORT, ending the window early.
  - `round_count`, REPORT and GAP behave unchanged.
- Undefined: SHOW always lasts the full WINDOW_CYCLES.

## Structure
- `mole_pkg`:
  - state enum `mole_state_t`
  - `NUM_MOLES`
  - LFSR width and tap constants
  - `round_cnt_t` (8-bit)
- Sub-module `mole_lfsr`: seedable 32-bit LFSR with synchronous active-low reset, output bus `lfsr`.
- Window and gap share one down-counter sized $clog2 of max(WINDOW_CYCLES, GAP_CYCLES)+1.

## Test plan
Bench uses WINDOW_CYCLES=8, GAP_CYCLES=4, NUM_ROUNDS=3.
- Reset then `start` 1 cycle:
  - SPAWN, 8 SHOW cycles with a nonzero `led_moles`, REPORT, then 4 dark cycles.
  - The first `round_done` comes exactly 10 cycles after the start edge.
- Press every lit mole once during SHOW → `hit_reg`==`led_moles` in REPORT and 0 in all other cycles.
- Press only dark moles, and hold one lit button across the whole window from SPAWN → `hit_reg`=0.
- Run 3 rounds → `round_count` steps 1, 2, 3, then DONE with `game_over`=1. `start` then restarts the game with `round_count`=0.
- Assert `reset`=0 mid-SHOW → next cycle all outputs 0, IDLE. The following pattern sequence repeats the post-reset sequence (SEED).
- `MOLE_EARLY_CLEAR_EN`: hit all lit moles at SHOW cycle 3 → `round_done` at cycle 5 after start. Without the macro, `round_done` stays at cycle 10.
